serializer_word_scheduler: RTL and testbench

//  Feeds the K-level tree serializer one M-bit word per M-cycle frame.

---
 rtl/serializer_word_scheduler.sv | 165 ++++++++++++++++
 tb/tb_serializer_word_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_word_scheduler.sv
// serializer_word_scheduler
//   Feeds a K-level tree serializer one M-bit word (M = 2**K) per M-cycle frame.
//   Upstream words enter a DEPTH-entry FIFO through valid/ready. The lane holds
//   ser_din stable for a whole frame, runs a slot counter, substitutes IDLE_WORD
//   when the FIFO is empty, and starts/stops cleanly on frame boundaries.
//
// Ports
//   clk          lane clock, rising edge
//   rst          asynchronous reset, active low
//   enable       1 = run the lane, 0 = stop at the next frame boundary
//   in_valid     upstream word valid
//   in_data      upstream word (M bits)
//   in_ready     FIFO not full
//   ser_din      registered word to the serializer, stable for a frame
//   ser_slot     bit slot 0..M-1 within the current frame
//   frame_start  slot 0 of an active frame
//   busy         lane not idle
//   fifo_level   number of stored words
//   uf_count     saturating count of frames filled with IDLE_WORD
module serializer_word_scheduler #(
  parameter int unsigned      K         = 3,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [2**K-1:0]  IDLE_WORD = 8'hA5,
  parameter int unsigned      UF_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       in_valid,
  input  logic [2**K-1:0]            in_data,
  output logic                       in_ready,
  output logic [2**K-1:0]            ser_din,
  output logic [K-1:0]               ser_slot,
  output logic                       frame_start,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [UF_W-1:0]            uf_count
);

  localparam int unsigned M  = 2**K;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [K-1:0] SlotLast = K'(M - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [K-1:0]    slot_q, slot_d;
  logic [M-1:0]    din_q, din_d;
  logic [UF_W-1:0] uf_q, uf_d;
  logic [LW-1:0]   level_q, level_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [M-1:0]    mem_q [DEPTH];

  logic full, empty, push, pop, load;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  // Ready comes from the registered level only, so a pop never frees a slot
  // in the same cycle.
  assign push  = in_valid && !full;
  assign pop   = load && !empty;

  // Lane sequencing. RUN and DRAIN both count slots; the only difference is
  // what happens at the boundary, which is decided by enable at that edge.
  // enable=0 seen on the last slot of a RUN frame stops the lane right there
  // rather than draining a further frame.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    din_d   = din_q;
    uf_d    = uf_q;
    load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        slot_d = '0;
        if (enable) begin
          load    = 1'b1;
          state_d = StRun;
        end
      end
      StRun, StDrain: begin
        slot_d = slot_q + K'(1);
        if (slot_q == SlotLast) begin
          if (enable) begin
            load    = 1'b1;
            state_d = StRun;
          end else begin
            din_d   = IDLE_WORD;
            state_d = StIdle;
          end
        end else begin
          state_d = enable ? StRun : StDrain;
        end
      end
      default: begin
        state_d = StIdle;
        slot_d  = '0;
        din_d   = IDLE_WORD;
      end
    endcase

    // A word pushed on this same edge is not yet counted in level_q, so an
    // empty FIFO here always means an underflow frame.
    if (load) begin
      if (!empty) begin
        din_d = mem_q[rd_ptr_q];
      end else begin
        din_d = IDLE_WORD;
        if (uf_q != '1) begin
          uf_d = uf_q + UF_W'(1);
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      slot_q   <= '0;
      din_q    <= IDLE_WORD;
      uf_q     <= '0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      din_q    <= din_d;
      uf_q     <= uf_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign in_ready    = !full;
  assign ser_din     = din_q;
  assign ser_slot    = slot_q;
  assign busy        = (state_q != StIdle);
  assign frame_start = (state_q != StIdle) && (slot_q == '0);
  assign fifo_level  = level_q;
  assign uf_count    = uf_q;

endmodule

// File: tb/tb_serializer_word_scheduler.sv
module tb_serializer_word_scheduler;

  localparam int M     = 8;
  localparam int DEPTH = 4;
  localparam logic [7:0] IDLE = 8'hA5;
  localparam int UF_MAX = 65535;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic        in_ready, frame_start, busy;
  logic [7:0]  ser_din;
  logic [2:0]  ser_slot, fifo_level;
  logic [15:0] uf_count;

  // Second instance with a 2-bit underflow counter, never fed, to show saturation.
  logic        s_ready, s_fs, s_busy;
  logic [7:0]  s_din;
  logic [2:0]  s_slot, s_level;
  logic [1:0]  s_uf;

  always #5 clk = ~clk;

  serializer_word_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ser_din(ser_din), .ser_slot(ser_slot),
    .frame_start(frame_start), .busy(busy), .fifo_level(fifo_level), .uf_count(uf_count)
  );

  serializer_word_scheduler #(.UF_W(2)) dut_sat (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(1'b0), .in_data(in_data),
    .in_ready(s_ready), .ser_din(s_din), .ser_slot(s_slot),
    .frame_start(s_fs), .busy(s_busy), .fifo_level(s_level), .uf_count(s_uf)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference model: a word queue plus "lane active" and a position in the
  // frame. Every boundary (idle, or last slot) either loads or parks the lane.
  logic [7:0] mq[$];
  int         m_slot;
  bit         m_active;
  logic [7:0] m_din;
  int         m_uf;
  bit         m_pushed;
  bit         m_take, m_boundary;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_slot = 0; m_active = 0; m_din = IDLE; m_uf = 0; m_pushed = 0;
    end else begin
      m_take     = in_valid && (mq.size() < DEPTH);
      m_boundary = !m_active || (m_slot == M - 1);
      if (m_boundary) begin
        if (enable) begin
          if (mq.size() > 0) m_din = mq.pop_front();
          else begin
            m_din = IDLE;
            if (m_uf < UF_MAX) m_uf++;
          end
        end else begin
          m_din = IDLE;
        end
        m_active = enable;
        m_slot   = 0;
      end else begin
        m_slot++;
      end
      if (m_take) mq.push_back(in_data);
      m_pushed = m_take;
    end
  end

  task automatic check_model(input string tag);
    chk({tag, ".din"},   32'(ser_din),     32'(m_din));
    chk({tag, ".slot"},  32'(ser_slot),    32'(m_slot));
    chk({tag, ".fs"},    32'(frame_start), 32'(m_active && m_slot == 0));
    chk({tag, ".busy"},  32'(busy),        32'(m_active));
    chk({tag, ".level"}, 32'(fifo_level),  32'(mq.size()));
    chk({tag, ".ready"}, 32'(in_ready),    32'(mq.size() < DEPTH));
    chk({tag, ".uf"},    32'(uf_count),    32'(m_uf));
  endtask

  // Called at a falling edge; drives inputs, checks after the next falling edge.
  task automatic step(input bit v, input logic [7:0] d, input bit en);
    in_valid = v;
    in_data  = d;
    enable   = en;
    @(negedge clk);
    check_model("model");
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         en;
    logic [7:0] e_din;
    int         e_slot;
    bit         e_fs;
    bit         e_busy;
    int         e_lvl;
    int         e_uf;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] words[40];
  int         idx, nfr, cyc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Start sequence: push D3 while idle, enable, frame of 8, then underflow, then drain.
    tbl.push_back('{1, 8'hD3, 0, IDLE,  0, 0, 0, 1, 0});
    tbl.push_back('{0, 8'h00, 1, 8'hD3, 0, 1, 1, 0, 0});
    for (int s = 1; s < 8; s++) tbl.push_back('{0, 8'h00, 1, 8'hD3, s, 0, 1, 0, 0});
    tbl.push_back('{0, 8'h00, 1, IDLE,  0, 1, 1, 0, 1});
    tbl.push_back('{0, 8'h00, 0, IDLE,  1, 0, 1, 0, 1});

    @(negedge clk);
    do_reset();
    // Reset values
    chk("rst.din", 32'(ser_din), 32'(IDLE));
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd1);

    // T2 table
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      enable   = tbl[i].en;
      @(negedge clk);
      chk($sformatf("t2[%0d].din", i),   32'(ser_din),     32'(tbl[i].e_din));
      chk($sformatf("t2[%0d].slot", i),  32'(ser_slot),    32'(tbl[i].e_slot));
      chk($sformatf("t2[%0d].fs", i),    32'(frame_start), 32'(tbl[i].e_fs));
      chk($sformatf("t2[%0d].busy", i),  32'(busy),        32'(tbl[i].e_busy));
      chk($sformatf("t2[%0d].level", i), 32'(fifo_level),  32'(tbl[i].e_lvl));
      chk($sformatf("t2[%0d].uf", i),    32'(uf_count),    32'(tbl[i].e_uf));
    end

    // T1: reset mid-frame with 3 words queued
    do_reset();
    step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0); step(1, 8'h44, 1);
    step(0, 8'h00, 1); step(0, 8'h00, 1);
    #2 rst = 1'b0;
    #1;
    chk("t1.din",   32'(ser_din),     32'(IDLE));
    chk("t1.slot",  32'(ser_slot),    32'd0);
    chk("t1.fs",    32'(frame_start), 32'd0);
    chk("t1.busy",  32'(busy),        32'd0);
    chk("t1.level", 32'(fifo_level),  32'd0);
    chk("t1.uf",    32'(uf_count),    32'd0);
    chk("t1.ready", 32'(in_ready),    32'd1);
    enable = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(0, 8'h00, 0);

    // T3: streaming 40 random words
    do_reset();
    foreach (words[i]) words[i] = 8'($urandom);
    idx = 0; nfr = 0; cyc = 0;
    while (nfr < 40 && cyc < 2000) begin
      step(idx < 40, (idx < 40) ? words[idx] : 8'h00, idx >= 4);
      cyc++;
      if (m_pushed) idx++;
      if (frame_start) begin
        chk($sformatf("t3.order[%0d]", nfr), 32'(ser_din), 32'(words[nfr]));
        nfr++;
      end
    end
    chk("t3.frames", 32'(nfr), 32'd40);
    chk("t3.uf", 32'(uf_count), 32'd0);
    repeat (16) step(0, 8'h00, 0);

    // T4: underflow and saturation
    do_reset();
    repeat (17) step(0, 8'h00, 1);
    chk("t4.din", 32'(ser_din), 32'(IDLE));
    chk("t4.uf3", 32'(uf_count), 32'd3);
    chk("t4.sat3", 32'(s_uf), 32'd3);
    repeat (16) step(0, 8'h00, 1);
    chk("t4.uf5", 32'(uf_count), 32'd5);
    chk("t4.sat", 32'(s_uf), 32'd3);
    repeat (16) step(0, 8'h00, 0);

    // T5: full FIFO
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(1, 8'hB0 + 8'(i), 0);
      chk($sformatf("t5.level[%0d]", i), 32'(fifo_level), 32'((i + 1 < DEPTH) ? i + 1 : DEPTH));
      chk($sformatf("t5.ready[%0d]", i), 32'(in_ready), 32'(i + 1 < DEPTH));
    end
    step(0, 8'h00, 1);
    for (int f = 0; f < 5; f++) begin
      chk($sformatf("t5.fs[%0d]", f), 32'(frame_start), 32'd1);
      chk($sformatf("t5.word[%0d]", f), 32'(ser_din), 32'((f < 4) ? 8'hB0 + 8'(f) : IDLE));
      repeat (8) step(0, 8'h00, 1);
    end
    repeat (16) step(0, 8'h00, 0);

    // T6: stop at slot 2, then re-enable inside a draining frame
    do_reset();
    step(1, 8'hC1, 0); step(1, 8'hC2, 0); step(1, 8'hC3, 0);
    step(0, 8'h00, 1);
    chk("t6.first", 32'(ser_din), 32'hC1);
    step(0, 8'h00, 1); step(0, 8'h00, 1);
    chk("t6.slot2", 32'(ser_slot), 32'd2);
    for (int s = 3; s < 8; s++) begin
      step(0, 8'h00, 0);
      chk($sformatf("t6.drain_busy[%0d]", s), 32'(busy), 32'd1);
      chk($sformatf("t6.drain_din[%0d]", s), 32'(ser_din), 32'hC1);
    end
    step(0, 8'h00, 0);
    chk("t6.idle_busy", 32'(busy), 32'd0);
    chk("t6.idle_din", 32'(ser_din), 32'(IDLE));
    chk("t6.kept", 32'(fifo_level), 32'd2);
    step(0, 8'h00, 1);
    chk("t6.second", 32'(ser_din), 32'hC2);
    step(0, 8'h00, 1); step(0, 8'h00, 1);
    step(0, 8'h00, 0); step(0, 8'h00, 0);
    repeat (3) step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    chk("t6.nogap_din", 32'(ser_din), 32'hC3);
    chk("t6.nogap_fs", 32'(frame_start), 32'd1);
    chk("t6.nogap_level", 32'(fifo_level), 32'd0);
    repeat (16) step(0, 8'h00, 0);

    // Random traffic against the model
    do_reset();
    enable = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int rate;
      bit en;
      rate = (c / 500) % 3;
      en = enable;
      if ($urandom_range(0, 24) == 0) en = !en;
      step((rate == 0) ? ($urandom_range(0, 5) == 0) :
           (rate == 1) ? ($urandom_range(0, 1) == 0) : 1'b1,
           8'($urandom), en);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
